// File: rtl/encoder_4to2_pending.sv
// Sequential 4-to-2 priority encoder. Requests are latched into a pending
// register and granted one per load slot, highest index first, with VALID/ACK.
module encoder_4to2_pending #(
    parameter int EDGE_MODE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       EN,
    input  logic       D3,
    input  logic       D2,
    input  logic       D1,
    input  logic       D0,
    input  logic       ACK,
    output logic       A,
    output logic       B,
    output logic       VALID,
    output logic [3:0] PEND,
    output logic       OVF
);

    logic [3:0] d;
    logic [3:0] prev_d;
    logic [3:0] cap;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       load;
    logic       lost;

    assign d    = {D3, D2, D1, D0};
    assign load = !VALID || ACK;

    generate
        if (EDGE_MODE != 0) begin : g_edge
            assign cap  = d & ~prev_d & {4{EN}};
            assign lost = |(cap & PEND & ~grant);
        end else begin : g_level
            // A held line re-captures every cycle, so losing one is expected.
            assign cap  = d & {4{EN}};
            assign lost = 1'b0;
        end
    endgenerate

    // Priority is resolved on the pending set at grant time, not capture time.
    always_comb begin
        grant     = 4'b0000;
        grant_idx = 2'b00;
        if (load) begin
            casez (PEND)
                4'b1???: begin grant = 4'b1000; grant_idx = 2'd3; end
                4'b01??: begin grant = 4'b0100; grant_idx = 2'd2; end
                4'b001?: begin grant = 4'b0010; grant_idx = 2'd1; end
                4'b0001: begin grant = 4'b0001; grant_idx = 2'd0; end
                default: begin grant = 4'b0000; grant_idx = 2'd0; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_d <= 4'b0000;
            PEND   <= 4'b0000;
            VALID  <= 1'b0;
            A      <= 1'b0;
            B      <= 1'b0;
            OVF    <= 1'b0;
        end else begin
            prev_d <= d;
            // Set wins: a capture on the bit being granted re-pends it.
            PEND   <= (PEND & ~grant) | cap;
            if (load) begin
                if (PEND != 4'b0000) begin
                    {A, B} <= grant_idx;
                    VALID  <= 1'b1;
                end else begin
                    VALID  <= 1'b0;
                end
            end
            if (lost)
                OVF <= 1'b1;
        end
    end

endmodule

// File: tb/tb_encoder_4to2_pending.sv
// Scoreboard bench: a set-based model predicts grants into a queue; a monitor
// pops one entry each time the DUT presents a fresh code.
module tb_encoder_4to2_pending;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       EN = 1'b0;
    logic       D3 = 1'b0, D2 = 1'b0, D1 = 1'b0, D0 = 1'b0;
    logic       ACK = 1'b0;
    logic       A, B, VALID, OVF;
    logic [3:0] PEND;

    int tests = 0;
    int errors = 0;

    encoder_4to2_pending #(.EDGE_MODE(1)) dut (
        .clk(clk), .rst(rst), .EN(EN),
        .D3(D3), .D2(D2), .D1(D1), .D0(D0),
        .ACK(ACK), .A(A), .B(B), .VALID(VALID), .PEND(PEND), .OVF(OVF)
    );

    always #5 clk = ~clk;

    // Reference model: the pending set is a plain array of flags.
    bit   m_req [4];
    bit   m_prev[4];
    bit   m_valid, m_ovf;
    int   exp_q[$];
    bit   mon_en = 1'b0;

    function automatic logic [3:0] m_pend_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_req[i];
        return v;
    endfunction

    task automatic model_step(input bit r, input bit en, input bit [3:0] dv, input bit ack);
        int  hi;
        bit  newreq[4];
        if (r) begin
            for (int i = 0; i < 4; i++) begin m_req[i] = 0; m_prev[i] = 0; end
            m_valid = 0;
            m_ovf   = 0;
            exp_q.delete();
            return;
        end
        for (int i = 0; i < 4; i++) newreq[i] = en && dv[i] && !m_prev[i];
        hi = -1;
        if (!m_valid || ack) begin
            for (int i = 3; i >= 0; i--)
                if (hi < 0 && m_req[i]) hi = i;
            m_valid = (hi >= 0);
            if (hi >= 0) exp_q.push_back(hi);
        end
        for (int i = 0; i < 4; i++) begin
            if (newreq[i] && m_req[i] && i != hi) m_ovf = 1;
            if (i == hi) m_req[i] = 0;
            if (newreq[i]) m_req[i] = 1;
            m_prev[i] = dv[i];
        end
    endtask

    task automatic step(input bit r, input bit en, input bit [3:0] dv, input bit ack);
        @(negedge clk);
        rst = r; EN = en; {D3, D2, D1, D0} = dv; ACK = ack;
        @(posedge clk);
        model_step(r, en, dv, ack);
        mon_en = 1'b1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a code is fresh when VALID is up and the previous slot was
    // empty or was just acknowledged.
    initial begin : monitor
        bit prev_valid = 1'b0;
        int exp_code;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                check("pend", PEND, m_pend_vec());
                check("ovf", OVF, m_ovf);
                check("valid", VALID, m_valid);
                if (VALID === 1'b1 && (!prev_valid || ACK)) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_code", {A, B}, -1);
                    end else begin
                        exp_code = exp_q.pop_front();
                        check("code", {A, B}, exp_code);
                    end
                end
                prev_valid = (VALID === 1'b1);
            end
        end
    end

    initial begin
        // Reset with all lines high, then release.
        step(1, 1, 4'b1111, 0);
        step(1, 1, 4'b1111, 0);
        step(0, 1, 4'b0000, 0);
        check("rst_ab", {A, B}, 0);
        // Single request, held until ACK.
        step(0, 1, 4'b0100, 0);
        repeat (3) step(0, 1, 4'b0100, 0);
        step(0, 1, 4'b0000, 1);
        step(0, 1, 4'b0000, 0);
        // Priority and drain with ACK held.
        step(0, 1, 4'b1011, 1);
        repeat (4) step(0, 1, 4'b0000, 1);
        // Disable, then enable with a line already high.
        step(0, 0, 4'b0010, 0);
        step(0, 1, 4'b0010, 0);
        step(0, 1, 4'b0010, 0);
        step(0, 1, 4'b0000, 0);
        step(0, 1, 4'b0010, 1);
        repeat (2) step(0, 1, 4'b0000, 1);
        // Overflow while bit 0 is blocked behind code 11.
        step(0, 1, 4'b1001, 0);
        step(0, 1, 4'b0000, 0);
        step(0, 1, 4'b0001, 0);
        repeat (3) step(0, 1, 4'b0000, 1);
        // Same-cycle re-pend of bit 3.
        step(1, 0, 4'b0000, 0);
        step(0, 1, 4'b0100, 0);
        step(0, 1, 4'b1000, 0);
        step(0, 1, 4'b0000, 0);
        step(0, 1, 4'b1000, 1);
        step(0, 1, 4'b1000, 1);
        step(0, 1, 4'b0000, 1);
        // Reset mid-transaction with VALID=1, PEND=0110.
        step(0, 1, 4'b1000, 0);
        step(0, 1, 4'b0110, 0);
        step(1, 1, 4'b0110, 0);
        step(0, 1, 4'b0000, 0);
        // Randomized traffic.
        for (int n = 0; n < 3000; n++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8,
                 4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
        repeat (6) step(0, 1, 4'b0000, 1);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
